// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit arbiter.
//   arb_state_t : arbiter FSM state encoding
//   MAX_REQ     : largest number of requesters the arbiter is built for
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Purely combinational round-robin picker. The search starts at
// (last_grant + 1) mod NUM_REQ and wraps, so last_grant itself has the lowest
// priority.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    index of the previous winner
//   grant      out NUM_REQ  one-hot winner (zero when no request)
//   index      out IDX_W    binary index of the winner
//   any_valid  out 1        at least one request is present
// ---------------------------------------------------------------------------
module rr_select
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any_valid
);

    // cand_idx[gi] is the requester examined at search step gi + 1.
    logic [IDX_W-1:0] cand_idx [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(last_grant) + gi + 1) % NUM_REQ);
        end
    endgenerate

    // Walk the candidates from the farthest to the nearest so the nearest
    // requesting candidate is the last (winning) assignment.
    always_comb begin
        grant = '0;
        index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                grant              = '0;
                grant[cand_idx[i]] = 1'b1;
                index              = cand_idx[i];
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte sources. In IDLE one
// requester is picked round-robin and accepted with a one-hot o_ready strobe;
// the byte is registered, o_tx_start pulses for one cycle, and the arbiter
// waits for the transmitter to raise and then drop i_tx_busy before the next
// accept. The transmitter is instantiated by the level above.
// Optional build macro:
//   UART_TX_ARB_LOCK_EN : a byte accepted with i_last=0 locks arbitration to
//                         that requester until a byte with i_last=1 is taken.
//                         When undefined, i_last is ignored.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_valid         per-requester byte valid
//   i_data          requester k at [k*DATA_BITS +: DATA_BITS]
//   i_last          per-requester end-of-packet marker
//   o_ready         one-hot accept strobe (only in IDLE)
//   o_grant_id      index of the most recently accepted requester
//   o_tx_data       registered byte to the transmitter
//   o_tx_start      one-cycle start pulse to the transmitter
//   i_tx_busy       transmitter busy
//   o_busy          high whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   i_data,
    input  logic [NUM_REQ-1:0]             i_last,
    output logic [NUM_REQ-1:0]             o_ready,
    output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
    output logic [DATA_BITS-1:0]           o_tx_data,
    output logic                           o_tx_start,
    input  logic                           i_tx_busy,
    output logic                           o_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t             state_reg, state_next;
    logic [IDX_W-1:0]       last_grant_reg;
    logic [IDX_W-1:0]       grant_id_reg;
    logic [DATA_BITS-1:0]   tx_data_reg;

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     win_onehot;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic                   accept;

    // Per-requester byte lanes.
    logic [DATA_BITS-1:0]   req_byte [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign req_byte[gi] = i_data[gi*DATA_BITS +: DATA_BITS];
        end
    endgenerate

`ifdef UART_TX_ARB_LOCK_EN
    logic                   lock_reg;
    logic [IDX_W-1:0]       lock_id_reg;
    logic [NUM_REQ-1:0]     lock_mask;

    // While a packet is in progress only its owner may be picked.
    always_comb begin
        lock_mask = '1;
        if (lock_reg) begin
            lock_mask              = '0;
            lock_mask[lock_id_reg] = 1'b1;
        end
    end

    assign eligible = i_valid & lock_mask;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lock_reg    <= 1'b0;
            lock_id_reg <= '0;
        end else if (accept) begin
            lock_reg    <= ~i_last[win_idx];
            lock_id_reg <= win_idx;
        end
    end
`else
    logic last_unused;

    assign eligible    = i_valid;
    assign last_unused = ^i_last;
`endif

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req        (eligible),
        .last_grant (last_grant_reg),
        .grant      (win_onehot),
        .index      (win_idx),
        .any_valid  (win_any)
    );

    // Next-state and strobes. The accept is gated by reset so no byte is
    // consumed on an edge that is about to clear the arbiter.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        o_ready    = '0;
        o_tx_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_any && !i_reset) begin
                    accept     = 1'b1;
                    o_ready    = win_onehot;
                    state_next = START;
                end
            end
            START: begin
                o_tx_start = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            grant_id_reg   <= '0;
            tx_data_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                tx_data_reg    <= req_byte[win_idx];
                grant_id_reg   <= win_idx;
                last_grant_reg <= win_idx;
            end
        end
    end

    assign o_tx_data  = tx_data_reg;
    assign o_grant_id = grant_id_reg;
    assign o_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Pairs the arbiter with a behavioural UART transmitter (BAUD_DIV=4) and
// per-requester byte queues. A transaction-level model predicts o_ready,
// o_busy, o_tx_start, o_tx_data and o_grant_id every cycle; directed tests
// pin grant orders, serial bits and reset behaviour with literal values.
// Build with +define+UART_TX_ARB_LOCK_EN to exercise packet locking.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_BITS = 8;
    localparam int BAUD_DIV  = 4;
    localparam int QD        = 64;

    localparam int P_FREE      = 0; // arbiter can accept
    localparam int P_STARTING  = 1; // start pulse due this cycle
    localparam int P_AWAIT_TX  = 2; // waiting for transmitter to go busy
    localparam int P_TX_ACTIVE = 3; // waiting for transmitter to finish

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  tb_valid = '0;
    logic [31:0] tb_data  = '0;
    logic [3:0]  tb_last  = '0;
    logic [3:0]  o_ready;
    logic [1:0]  o_grant_id;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        tx_busy;
    logic        o_busy;
    logic        tx_line;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_valid    (tb_valid),
        .i_data     (tb_data),
        .i_last     (tb_last),
        .o_ready    (o_ready),
        .o_grant_id (o_grant_id),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_busy  (tx_busy),
        .o_busy     (o_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural transmitter -----------------------------
    logic       stub_en   = 1'b0;
    logic       stub_busy = 1'b0;
    logic [8:0] tx_sh;
    int         bcnt, bidx;
    logic [7:0] tx_bytes [256];
    logic       bit_log  [2048];
    int         n_tx   = 0;
    int         n_bits = 0;

    always @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            bcnt    <= 0;
            bidx    <= 0;
        end else if (stub_en) begin
            tx_busy <= stub_busy;
            tx_line <= 1'b1;
        end else if (!tx_busy) begin
            if (o_tx_start) begin
                tx_sh            <= {1'b1, o_tx_data};
                tx_busy          <= 1'b1;
                tx_line          <= 1'b0;
                bcnt             <= 0;
                bidx             <= 0;
                tx_bytes[n_tx]   <= o_tx_data;
                n_tx             <= n_tx + 1;
                bit_log[n_bits]  <= 1'b0;
                n_bits           <= n_bits + 1;
            end
        end else if (bcnt == BAUD_DIV - 1) begin
            bcnt <= 0;
            if (bidx == 9) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                tx_line         <= tx_sh[0];
                tx_sh           <= tx_sh >> 1;
                bidx            <= bidx + 1;
                bit_log[n_bits] <= tx_sh[0];
                n_bits          <= n_bits + 1;
            end
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    // ---------------- model + compare process ----------------------------
    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (last + k) % NUM_REQ;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    bit   m_ok = 1'b0;
    int   m_phase, m_last, m_data, m_gid, m_lock_id;
    bit   m_lock;
    int   cyc = 0;
    int   acc_cyc = 0, start_cyc = 0;
    int   grant_log [256];
    int   n_grant = 0;
    int   acc_cnt [NUM_REQ] = '{default: 0};

    always @(negedge clk) begin : compare
        int         win;
        logic [3:0] elig, exp_ready, acc;
        cyc = cyc + 1;
        if (rst) begin
            m_ok      = 1'b1;
            m_phase   = P_FREE;
            m_last    = NUM_REQ - 1;
            m_lock    = 1'b0;
            m_lock_id = 0;
            m_data    = 0;
            m_gid     = 0;
        end else if (m_ok) begin
            elig = tb_valid;
`ifdef UART_TX_ARB_LOCK_EN
            if (m_lock) elig = tb_valid & (4'b0001 << m_lock_id);
`endif
            win       = rr_pick(elig, m_last);
            exp_ready = '0;
            if (m_phase == P_FREE && win >= 0) exp_ready[win] = 1'b1;
            chk("ready", int'(o_ready), int'(exp_ready));
            chk("busy", int'(o_busy), (m_phase != P_FREE) ? 1 : 0);
            chk("tx_start", int'(o_tx_start), (m_phase == P_STARTING) ? 1 : 0);
            chk("tx_data", int'(o_tx_data), m_data);
            chk("grant_id", int'(o_grant_id), m_gid);

            acc = tb_valid & o_ready;
            if (acc != '0) begin
                chk("onehot", $countones(acc), 1);
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (acc[k]) begin
                        grant_log[n_grant] = k;
                        acc_cnt[k]         = acc_cnt[k] + 1;
                    end
                end
                n_grant = n_grant + 1;
                acc_cyc = cyc;
            end
            if (o_tx_start) start_cyc = cyc;

            case (m_phase)
                P_FREE: begin
                    if (win >= 0) begin
                        m_data  = int'(tb_data[win*8 +: 8]);
                        m_gid   = win;
                        m_last  = win;
`ifdef UART_TX_ARB_LOCK_EN
                        m_lock    = !tb_last[win];
                        m_lock_id = win;
`endif
                        m_phase = P_STARTING;
                    end
                end
                P_STARTING:  m_phase = P_AWAIT_TX;
                P_AWAIT_TX:  if (tx_busy)  m_phase = P_TX_ACTIVE;
                P_TX_ACTIVE: if (!tx_busy) m_phase = P_FREE;
                default:     m_phase = P_FREE;
            endcase
        end
    end

    // ---------------- requester queues ------------------------------------
    logic [8:0] src_mem [NUM_REQ][QD];
    int head   [NUM_REQ] = '{default: 0};
    int tail   [NUM_REQ] = '{default: 0};
    int popped [NUM_REQ] = '{default: 0};
    int g_base = 0, t_base = 0, b_base = 0;

    task automatic push(input int k, input logic [7:0] d, input logic l);
        src_mem[k][tail[k]] = {l, d};
        tail[k]++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            while (popped[k] < acc_cnt[k]) begin
                popped[k]++;
                if (head[k] < tail[k]) head[k]++;
            end
            tb_valid[k]        = head[k] < tail[k];
            tb_data[k*8 +: 8]  = tb_valid[k] ? src_mem[k][head[k]][7:0] : 8'h00;
            tb_last[k]         = tb_valid[k] ? src_mem[k][head[k]][8] : 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) head[k] = tail[k];
        cycle();
        cycle();
        rst    = 1'b0;
        g_base = n_grant;
        t_base = n_tx;
        b_base = n_bits;
    endtask

    task automatic wait_grants(input int target, input int budget);
        int t = 0;
        while (n_grant < target && t < budget) begin
            cycle();
            t++;
        end
        chk("grant_wait_done", (n_grant >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((o_busy || tx_busy) && t < budget) begin
            cycle();
            t++;
        end
        chk("idle_wait_done", int'(o_busy | tx_busy), 0);
    endtask

    // ---------------- directed tests --------------------------------------
    int exp_bits  [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int exp_rr    [5]  = '{0, 1, 2, 3, 0};
`ifdef UART_TX_ARB_LOCK_EN
    int exp_pkt   [5]  = '{2, 2, 2, 0, 0};
`else
    int exp_pkt   [5]  = '{2, 0, 2, 0, 2};
`endif

    initial begin
        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ready", int'(o_ready), 0);
        chk("rst_start", int'(o_tx_start), 0);
        chk("rst_tx_data", int'(o_tx_data), 0);
        chk("rst_grant_id", int'(o_grant_id), 0);
        chk("rst_line", int'(tx_line), 1);

        // Single byte 0xA5 from requester 0
        do_reset();
        push(0, 8'hA5, 1'b1);
        wait_grants(g_base + 1, 50);
        wait_idle(200);
        chk("t1_grant", grant_log[g_base], 0);
        chk("t1_start_latency", start_cyc - acc_cyc, 1);
        chk("t1_frames", n_tx - t_base, 1);
        chk("t1_byte", int'(tx_bytes[t_base]), 8'hA5);
        chk("t1_nbits", n_bits - b_base, 10);
        for (int i = 0; i < 10; i++) chk("t1_serial_bit", int'(bit_log[b_base + i]), exp_bits[i]);
        $display("txn single_byte: grant=%0d byte=%02h", grant_log[g_base], tx_bytes[t_base]);

        // All four requesters continuously valid
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            push(k, 8'(8'h10 + k), 1'b1);
            push(k, 8'(8'h10 + k), 1'b1);
        end
        wait_grants(g_base + 5, 400);
        for (int i = 0; i < 5; i++) chk("t2_rr_order", grant_log[g_base + i], exp_rr[i]);
        for (int i = 0; i < 4; i++) chk("t2_byte", int'(tx_bytes[t_base + i]), 8'h10 + i);
        $display("txn round_robin: grants=%0d,%0d,%0d,%0d,%0d", grant_log[g_base],
                 grant_log[g_base+1], grant_log[g_base+2], grant_log[g_base+3], grant_log[g_base+4]);

        // Packet from requester 2 while requester 0 is waiting
        do_reset();
        push(2, 8'h20, 1'b0);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        wait_grants(g_base + 1, 50);
        push(0, 8'h30, 1'b1);
        push(0, 8'h31, 1'b1);
        wait_grants(g_base + 5, 400);
        wait_idle(200);
        for (int i = 0; i < 5; i++) chk("t3_packet_order", grant_log[g_base + i], exp_pkt[i]);
        $display("txn packet: grants=%0d,%0d,%0d,%0d,%0d", grant_log[g_base],
                 grant_log[g_base+1], grant_log[g_base+2], grant_log[g_base+3], grant_log[g_base+4]);

        // Reset while the transmitter is mid-frame
        do_reset();
        push(0, 8'h44, 1'b1);
        wait_grants(g_base + 1, 50);
        repeat (12) cycle();
        chk("t4_pre_busy", int'(o_busy), 1);
        chk("t4_pre_txbusy", int'(tx_busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_busy", int'(o_busy), 0);
        chk("t4_start", int'(o_tx_start), 0);
        chk("t4_ready", int'(o_ready), 0);
        chk("t4_line", int'(tx_line), 1);
        do_reset();
        push(0, 8'h45, 1'b1);
        push(2, 8'h46, 1'b1);
        wait_grants(g_base + 1, 50);
        chk("t4_first_after_reset", grant_log[g_base], 0);
        wait_grants(g_base + 2, 200);
        wait_idle(200);
        $display("txn reset_abort: next_grant=%0d", grant_log[g_base]);

        // Transmitter stub holding busy low after the start pulse
        do_reset();
        stub_en   = 1'b1;
        stub_busy = 1'b0;
        push(1, 8'h51, 1'b1);
        push(2, 8'h52, 1'b1);
        wait_grants(g_base + 1, 50);
        chk("t5_grant", grant_log[g_base], 1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_ready_held", int'(o_ready), 0);
            chk("t5_busy_held", int'(o_busy), 1);
        end
        stub_busy = 1'b1;
        cycle();
        cycle();
        stub_busy = 1'b0;
        cycle();
        stub_en = 1'b0;
        wait_grants(g_base + 2, 50);
        chk("t5_next_grant", grant_log[g_base + 1], 2);
        wait_idle(200);
        $display("txn stub_busy_low: grants=%0d,%0d", grant_log[g_base], grant_log[g_base+1]);

        // Requester 1 withdraws in the cycle requester 3 arrives
        do_reset();
        push(0, 8'h60, 1'b1);
        wait_grants(g_base + 1, 50);
        push(1, 8'h61, 1'b1);
        repeat (10) cycle();
        head[1] = tail[1];
        push(3, 8'h63, 1'b1);
        wait_grants(g_base + 2, 200);
        wait_idle(200);
        repeat (5) cycle();
        chk("t6_grant_count", n_grant - g_base, 2);
        chk("t6_second_grant", grant_log[g_base + 1], 3);
        chk("t6_frames", n_tx - t_base, 2);
        chk("t6_byte0", int'(tx_bytes[t_base]), 8'h60);
        chk("t6_byte1", int'(tx_bytes[t_base + 1]), 8'h63);
        $display("txn withdraw: grants=%0d,%0d bytes=%02h,%02h", grant_log[g_base],
                 grant_log[g_base+1], tx_bytes[t_base], tx_bytes[t_base+1]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one transmitter; legal range 2..8.
REQ-002 Parameter DATA_BITS, default 8, byte width; SHALL match the attached transmitter.
REQ-003 i_clk  input  1  clock; all logic on rising edge.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 i_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 i_data  input  NUM_REQ*DATA_BITS  per-requester byte; requester k occupies bits [k*DATA_BITS +: DATA_BITS].
REQ-007 i_last  input  NUM_REQ  per-requester end-of-packet marker, qualified by i_valid.
REQ-008 o_ready  output  NUM_REQ  one-hot accept strobe; a byte transfers when i_valid[k] and o_ready[k] are high in the same cycle.
REQ-009 o_grant_id  output  $clog2(NUM_REQ)  index of the most recently accepted requester.
REQ-010 o_tx_data  output  DATA_BITS  registered byte to the transmitter.
REQ-011 o_tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-012 i_tx_busy  input  1  transmitter busy.
REQ-013 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 States: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: if any eligible i_valid, select the winner round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
- Same cycle: o_ready[winner]=1 (combinational).
- Next edge: latch byte into o_tx_data, set o_grant_id and last_grant, go to START.
REQ-016 o_ready SHALL be zero in every state except IDLE, and at most one bit SHALL be high.
REQ-017 START: o_tx_start=1 for exactly this cycle; next state WAIT_BUSY.
REQ-018 WAIT_BUSY: stay until i_tx_busy=1, then WAIT_DONE.
REQ-019 WAIT_DONE: stay until i_tx_busy=0, then IDLE.
REQ-020 Accept-to-start latency: one cycle. Start-to-next-accept: at least one transmitter frame plus three cycles.
REQ-021 o_tx_data SHALL hold stable from the accept edge until the next accept.
REQ-022 i_valid deasserted by a requester before its o_ready SHALL leave no state effect.
REQ-023 Simultaneous requests: exactly one winner per IDLE cycle. A requester held valid waits at most NUM_REQ-1 grants (no starvation).

Reset
REQ-024 i_reset SHALL force on the next edge:
- state=IDLE;
- o_tx_start=0, o_ready=0, o_busy=0;
- o_tx_data=0, o_grant_id=0;
- last_grant=NUM_REQ-1, so requester 0 has first priority;
- packet lock cleared.
REQ-025 Reset mid-frame SHALL abandon the frame without waiting for i_tx_busy. The transmitter SHALL share the same i_reset.

Configuration
REQ-026 Macro UART_TX_ARB_LOCK_EN defined:
- Accepting a byte with i_last=0 locks the grant to that requester.
- While locked, IDLE considers only that requester's i_valid.
- Accepting a byte with i_last=1 releases the lock.
REQ-027 Macro undefined: i_last is ignored and arbitration runs afresh for every byte.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum typedef and constant MAX_REQ=8.
REQ-029 Round-robin selection SHALL live in sub-module rr_select: inputs request vector and last_grant, outputs one-hot grant, index and any-valid; purely combinational.
REQ-030 The block SHALL not instantiate the transmitter; the top level connects the transmitter to it.

Verification (bench pairs the arbiter with the transmitter at BAUD_DIV=4, NUM_REQ=4)
REQ-031 Single byte: i_valid=4'b0001, byte 0xA5.
- Expect o_ready[0] pulse, then o_tx_start one cycle later.
- Expect serial line 0,1,0,1,0,0,1,0,1,1 (LSB first).
REQ-032 All four valid continuously, bytes 0x10..0x13.
- Expect grant order 0,1,2,3,0.
- Expect exactly one o_ready bit high per accept.
REQ-033 Lock enabled: requester 2 sends 3 bytes (i_last on the 3rd) while requester 0 is valid.
- Expect grants 2,2,2,0.
- Lock disabled: expect 2,0,2,0,2.
REQ-034 Reset asserted during WAIT_DONE.
- Next cycle expect o_busy=0, o_tx_start=0, o_ready=0.
- Expect line idle high; next grant goes to requester 0.
REQ-035 Hold transmitter busy low for 5 cycles after start (stub): expect the block to stay in WAIT_BUSY with o_ready=0 throughout.
REQ-036 Requester 1 drops i_valid the same cycle requester 3 raises it: expect requester 3 granted and no byte lost.
